wishbone_bus_if: RTL and testbench

Bus interface unit between the core's memory-side ports and a Wishbone B4 classic-cycle interconnect. Two instances are used: one on the instruction fetch port (pc/rom_*) and one on the data port (ram_*).
- Converts each single-cycle core request into a registered Wishbone cycle.
- Stalls the pipeline through ctrl until the cycle completes.
- Buffers read data across extra pipeline stalls.
- Aborts the cycle on flush.

---
 rtl/wishbone_bus_if_pkg.sv | 16 +
 rtl/wishbone_bus_if.sv | 151 +++++++++++++++
 tb/tb_wishbone_bus_if.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// rtl/wishbone_bus_if_pkg.sv - shared widths, constants and FSM encodings for the Wishbone bus interface
package wishbone_bus_if_pkg;

  localparam int   REG_BUS_W       = 32;
  localparam int   INST_ADDR_BUS_W = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wishbone_bus_if.sv
// rtl/wishbone_bus_if.sv - core-to-Wishbone B4 classic bus interface with stall, flush and timeout
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int ADDR_W  = INST_ADDR_BUS_W,
  parameter int DATA_W  = REG_BUS_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o
);

  localparam int SEL_W = DATA_W / 8;
  // Wide enough to hold TIMEOUT itself; at least one bit when the timeout is disabled.
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_state_e          state_q;
  logic [ADDR_W-1:0]  adr_q;
  logic [DATA_W-1:0]  dat_q;
  logic               we_q;
  logic [SEL_W-1:0]   sel_q;
  logic               stb_q;
  logic               cyc_q;
  logic [DATA_W-1:0]  rd_buf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bus_err_q;
  logic               timeout_hit;

  // The last permitted BUSY cycle without ack ends the cycle by force.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Bus cycle sequencer: state, registered Wishbone outputs, read buffer and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WB_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= DISABLE;
      sel_q     <= '0;
      stb_q     <= DISABLE;
      cyc_q     <= DISABLE;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= DISABLE;
    end else begin
      bus_err_q <= DISABLE;
      case (state_q)
        WB_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            adr_q   <= cpu_addr_i;
            dat_q   <= cpu_data_i;
            we_q    <= cpu_we_i;
            sel_q   <= cpu_sel_i;
            stb_q   <= ENABLE;
            cyc_q   <= ENABLE;
            cnt_q   <= '0;
            state_q <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (flush_i) begin
            // Flush wins over a coincident ack; the returned data is dropped.
            stb_q   <= DISABLE;
            cyc_q   <= DISABLE;
            we_q    <= DISABLE;
            sel_q   <= '0;
            state_q <= WB_IDLE;
          end else if (wb_ack_i) begin
            stb_q    <= DISABLE;
            cyc_q    <= DISABLE;
            we_q     <= DISABLE;
            sel_q    <= '0;
            rd_buf_q <= wb_dat_i;
            state_q  <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end else if (timeout_hit) begin
            stb_q     <= DISABLE;
            cyc_q     <= DISABLE;
            we_q      <= DISABLE;
            sel_q     <= '0;
            rd_buf_q  <= '0;
            bus_err_q <= ENABLE;
            state_q   <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end
        end
        WB_WAIT_FOR_STALL: begin
          if (flush_i || (stall_i == '0)) begin
            state_q <= WB_IDLE;
          end
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  // Stall request and read-data return toward the core.
  always_comb begin
    stallreq_o = DISABLE;
    cpu_data_o = '0;
    case (state_q)
      WB_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
      end
      WB_BUSY: begin
        if (!flush_i && wb_ack_i) begin
          cpu_data_o = wb_dat_i;
        end else if (!flush_i && !timeout_hit) begin
          stallreq_o = ENABLE;
        end
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq_o = DISABLE;
      end
    endcase
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = cyc_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// tb/tb_wishbone_bus_if.sv - self-checking bench for wishbone_bus_if
module tb_wishbone_bus_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall_i;
  logic          flush_i;
  logic          cpu_ce_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_data_i;
  logic          cpu_we_i;
  logic [SW-1:0] cpu_sel_i;
  logic [DW-1:0] cpu_data_o;
  logic          stallreq_o;
  logic          bus_err_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;

  int checks = 0;
  int errors = 0;

  // Reference view of the transaction in flight and of a pending error pulse.
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          req_we;
  logic [SW-1:0] req_sel;
  logic          exp_err = 1'b0;

  always #5 clk = ~clk;

  wishbone_bus_if #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o),
    .bus_err_o (bus_err_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the expected cycle behaviour.
  task automatic chk_cycle(input string tag, input logic ereq, input logic [DW-1:0] edata,
                           input logic ecyc, input logic edrop);
    chk({tag, ":stallreq"}, 64'(stallreq_o), 64'(ereq));
    chk({tag, ":cpu_data"}, 64'(cpu_data_o), 64'(edata));
    chk({tag, ":cyc"}, 64'(wb_cyc_o), 64'(ecyc));
    chk({tag, ":stb"}, 64'(wb_stb_o), 64'(ecyc));
    chk({tag, ":bus_err"}, 64'(bus_err_o), 64'(exp_err));
    if (ecyc) begin
      chk({tag, ":adr"}, 64'(wb_adr_o), 64'(req_adr));
      chk({tag, ":dat"}, 64'(wb_dat_o), 64'(req_dat));
      chk({tag, ":we"}, 64'(wb_we_o), 64'(req_we));
      chk({tag, ":sel"}, 64'(wb_sel_o), 64'(req_sel));
    end
    if (edrop) begin
      chk({tag, ":we_drop"}, 64'(wb_we_o), 64'(0));
      chk({tag, ":sel_drop"}, 64'(wb_sel_o), 64'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cpu_ce_i = 1'b0;
    flush_i  = 1'b0;
    wb_ack_i = 1'b0;
    stall_i  = '0;
  endtask

  // One IDLE cycle; optionally a request that is killed by a simultaneous flush.
  task automatic idle_cycle(input string tag, input logic ce_with_flush);
    cpu_ce_i   = ce_with_flush;
    flush_i    = ce_with_flush;
    cpu_addr_i = $urandom;
    wb_ack_i   = 1'($urandom_range(0, 1));
    wb_dat_i   = $urandom;
    stall_i    = 6'($urandom);
    @(negedge clk);
    chk_cycle(tag, 1'b0, '0, 1'b0, 1'b0);
    exp_err = 1'b0;
    tick();
    quiet();
  endtask

  // One complete core request: slave acks after `waits` BUSY cycles (timeout if
  // waits >= TO), flush at BUSY cycle fl_at (-1 = none), and wst cycles in
  // WAIT_FOR_STALL after the cycle ends.
  task automatic txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] rd,
                     input int waits, input int wst, input int fl_at);
    int   k;
    logic done, to, fl, is_end;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_we_i   = we;
    cpu_sel_i  = sel;
    flush_i    = 1'b0;
    wb_ack_i   = 1'($urandom_range(0, 1));
    wb_dat_i   = $urandom;
    stall_i    = 6'($urandom);
    req_adr = a; req_dat = d; req_we = we; req_sel = sel;
    @(negedge clk);
    chk_cycle({tag, ":req"}, 1'b1, '0, 1'b0, 1'b0);
    exp_err = 1'b0;
    tick();
    k = 0; done = 1'b0; to = 1'b0; fl = 1'b0;
    while (!done) begin
      cpu_ce_i   = 1'($urandom_range(0, 1));
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      cpu_we_i   = 1'($urandom_range(0, 1));
      cpu_sel_i  = SW'($urandom);
      wb_ack_i   = (k == waits);
      wb_dat_i   = (k == waits) ? rd : $urandom;
      flush_i    = (k == fl_at);
      is_end     = flush_i || wb_ack_i || (k == TO - 1);
      if (is_end) stall_i = (wst > 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      else        stall_i = 6'($urandom);
      @(negedge clk);
      if (flush_i)       chk_cycle({tag, ":flush"}, 1'b0, '0, 1'b1, 1'b0);
      else if (wb_ack_i) chk_cycle({tag, ":ack"}, 1'b0, rd, 1'b1, 1'b0);
      else if (k == TO - 1) chk_cycle({tag, ":timeout"}, 1'b0, '0, 1'b1, 1'b0);
      else               chk_cycle({tag, ":busy"}, 1'b1, '0, 1'b1, 1'b0);
      to = !flush_i && !wb_ack_i && (k == TO - 1);
      fl = flush_i;
      exp_err = to;
      done = is_end;
      tick();
      k++;
    end
    if (!fl) begin
      for (int j = 1; j <= wst; j++) begin
        flush_i    = 1'b0;
        stall_i    = (j < wst) ? 6'($urandom_range(1, 63)) : 6'd0;
        cpu_ce_i   = 1'($urandom_range(0, 1));
        cpu_addr_i = $urandom;
        wb_ack_i   = 1'($urandom_range(0, 1));
        wb_dat_i   = $urandom;
        @(negedge clk);
        chk_cycle({tag, ":wait"}, 1'b0, to ? '0 : rd, 1'b0, !to);
        exp_err = 1'b0;
        tick();
      end
    end
    quiet();
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0; wb_dat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:cyc", 64'(wb_cyc_o), 64'(0));
    chk("reset:stb", 64'(wb_stb_o), 64'(0));
    chk("reset:adr", 64'(wb_adr_o), 64'(0));
    chk("reset:dat", 64'(wb_dat_o), 64'(0));
    chk("reset:we", 64'(wb_we_o), 64'(0));
    chk("reset:sel", 64'(wb_sel_o), 64'(0));
    chk("reset:bus_err", 64'(bus_err_o), 64'(0));
    chk("reset:cpu_data", 64'(cpu_data_o), 64'(0));
    chk("reset:stallreq", 64'(stallreq_o), 64'(0));
    tick();
    rst = 1'b1;

    // Zero-wait read, then IDLE in the following cycle.
    txn("rd0", 32'h0000_0100, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D, 0, 0, -1);
    idle_cycle("rd0_idle", 1'b0);

    // Write with three wait states; ack lands on the last allowed BUSY cycle.
    txn("wr3", 32'h0000_2000, 32'h1234_5678, 1'b1, 4'b0011, 32'h0BAD_0BAD, 3, 0, -1);
    idle_cycle("wr3_idle", 1'b0);

    // Pipeline still stalled after ack: data held in WAIT_FOR_STALL.
    txn("stl", 32'h0000_0040, 32'h0, 1'b0, 4'hF, 32'hA5A5_A5A5, 1, 4, -1);
    idle_cycle("stl_idle", 1'b0);

    // Flush together with ack in wait cycle 2, then a back-to-back request.
    txn("fl", 32'h0000_3000, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 2, 0, 2);
    txn("fl_next", 32'h0000_3004, 32'h0, 1'b0, 4'hF, 32'h1111_2222, 0, 0, -1);

    // Timeout with no ack; the error pulse appears in the next cycle only.
    txn("to", 32'h0000_4000, 32'h0, 1'b0, 4'hF, 32'h0, 99, 0, -1);
    idle_cycle("to_pulse", 1'b0);
    idle_cycle("to_after", 1'b0);
    txn("to_stl", 32'h0000_4004, 32'h0, 1'b0, 4'hF, 32'h0, 99, 2, -1);
    idle_cycle("ce_flush_idle", 1'b1);
    idle_cycle("ce_flush_after", 1'b0);

    // Asynchronous reset in the middle of a BUSY cycle.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_5000; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
    tick();
    cpu_ce_i = 1'b0;
    @(negedge clk);
    chk("arst:cyc_before", 64'(wb_cyc_o), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst:cyc", 64'(wb_cyc_o), 64'(0));
    chk("arst:stb", 64'(wb_stb_o), 64'(0));
    chk("arst:adr", 64'(wb_adr_o), 64'(0));
    tick();
    rst = 1'b1;
    exp_err = 1'b0;
    txn("arst_fresh", 32'h0000_5004, 32'h0, 1'b0, 4'hF, 32'h7777_8888, 1, 0, -1);

    // Randomized transactions.
    for (int n = 0; n < 150; n++) begin
      int w, s, f;
      w = $urandom_range(0, 5);
      s = $urandom_range(0, 3);
      f = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 4)) : -1;
      txn("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), SW'($urandom), $urandom, w, s, f);
      if ($urandom_range(0, 1) == 1) idle_cycle("rnd_idle", 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
